// File: rtl/fw_rom_copy.sv
// Firmware-table consumer: copies every populated fw_store slot from DDR3 into SDRAM,
// packed back-to-back from RAM_BASE, then publishes per-slot base/valid and pulses update_ack.

package MSX;
    typedef struct packed {
        logic [7:0]  block_count;
        logic [27:0] store_address;
    } fw_rom_t;
endpackage

module fw_rom_copy #(
    parameter int          MAX_FW_ROM = 8,
    parameter logic [26:0] RAM_BASE   = 27'h0,
    parameter logic [26:0] RAM_LIMIT  = 27'h400000,
    parameter int          BLOCK_LOG2 = 14      // log2 of block size in bytes (16 KB)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             update_request,
    output logic                             update_ack,
    input  MSX::fw_rom_t [MAX_FW_ROM-1:0]    fw_store,
    output logic                             ddr3_request,
    output logic [27:0]                      ddr3_addr,
    output logic                             ddr3_rd,
    input  logic                             ddr3_ready,
    input  logic [7:0]                       ddr3_dout,
    output logic [26:0]                      ram_addr,
    output logic [7:0]                       ram_din,
    output logic                             ram_we,
    input  logic                             ram_ready,
    output logic [MAX_FW_ROM-1:0][26:0]      fw_ram_base,
    output logic [MAX_FW_ROM-1:0]            fw_ram_valid,
    output logic                             copy_overflow
);

    localparam int IDW = $clog2(MAX_FW_ROM + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SCAN    = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_WR      = 3'd4;
    localparam logic [2:0] S_ACK     = 3'd5;

    logic [2:0]     state_reg;
    logic           req_d_reg;
    logic           pending_reg;
    logic [IDW-1:0] id_reg;
    logic [26:0]    dst_reg;
    logic [27:0]    src_reg;
    logic [21:0]    len_reg;
    logic [21:0]    off_reg;
    logic           ddr3_rd_reg;
    logic [27:0]    ddr3_addr_reg;
    logic           ram_we_reg;
    logic [26:0]    ram_addr_reg;
    logic [7:0]     ram_din_reg;
    logic           overflow_reg;

    logic           req_edge;
    logic           pass_start;
    logic           last_byte;
    logic           at_limit_next;
    MSX::fw_rom_t   cur_slot;

    assign req_edge      = update_request & ~req_d_reg;
    assign pass_start    = ((state_reg == S_IDLE) || (state_reg == S_ACK)) && (req_edge || pending_reg);
    assign last_byte     = (off_reg == (len_reg - 22'd1));
    assign at_limit_next = ({1'b0, dst_reg} + 28'd1) >= {1'b0, RAM_LIMIT};

    always_comb begin
        cur_slot = '0;
        for (int i = 0; i < MAX_FW_ROM; i++) begin
            if (id_reg == IDW'(i)) begin
                cur_slot = fw_store[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            req_d_reg     <= 1'b0;
            pending_reg   <= 1'b0;
            id_reg        <= '0;
            dst_reg       <= '0;
            src_reg       <= '0;
            len_reg       <= '0;
            off_reg       <= '0;
            ddr3_rd_reg   <= 1'b0;
            ddr3_addr_reg <= '0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_din_reg   <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            req_d_reg <= update_request;

            if (pass_start) begin
                pending_reg  <= 1'b0;
                dst_reg      <= RAM_BASE;
                id_reg       <= '0;
                overflow_reg <= 1'b0;
            end else if (req_edge) begin
                pending_reg  <= 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (pass_start) begin
                        state_reg <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (id_reg == IDW'(MAX_FW_ROM)) begin
                        state_reg <= S_ACK;
                    end else if (cur_slot.block_count == 8'd0) begin
                        id_reg <= id_reg + 1'b1;
                    end else begin
                        src_reg <= cur_slot.store_address;
                        len_reg <= 22'(cur_slot.block_count) << BLOCK_LOG2;
                        off_reg <= '0;
                        // A slot starting at the limit gets no bytes at all
                        if (dst_reg >= RAM_LIMIT) begin
                            overflow_reg <= 1'b1;
                            id_reg       <= id_reg + 1'b1;
                        end else begin
                            state_reg <= S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (!ddr3_rd_reg) begin
                        ddr3_rd_reg   <= 1'b1;
                        ddr3_addr_reg <= src_reg + {6'd0, off_reg};
                    end else if (ddr3_ready) begin
                        ddr3_rd_reg <= 1'b0;
                        state_reg   <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (ddr3_ready) begin
                        ram_din_reg  <= ddr3_dout;
                        ram_addr_reg <= dst_reg;
                        ram_we_reg   <= 1'b1;
                        state_reg    <= S_WR;
                    end
                end
                S_WR: begin
                    if (ram_ready) begin
                        ram_we_reg <= 1'b0;
                        dst_reg    <= dst_reg + 27'd1;
                        off_reg    <= off_reg + 22'd1;
                        if (last_byte) begin
                            id_reg    <= id_reg + 1'b1;
                            state_reg <= S_SCAN;
                        end else if (at_limit_next) begin
                            overflow_reg <= 1'b1;
                            id_reg       <= id_reg + 1'b1;
                            state_reg    <= S_SCAN;
                        end else begin
                            state_reg <= S_RD_REQ;
                        end
                    end
                end
                S_ACK: begin
                    state_reg <= pass_start ? S_SCAN : S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Per-slot publication registers
    generate
        for (genvar gi = 0; gi < MAX_FW_ROM; gi++) begin : g_slot
            logic [26:0] base_reg;
            logic        valid_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    base_reg  <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    if (pass_start) begin
                        valid_reg <= 1'b0;
                    end else if ((state_reg == S_WR) && ram_ready && last_byte && (id_reg == IDW'(gi))) begin
                        valid_reg <= 1'b1;
                    end
                    if ((state_reg == S_SCAN) && (id_reg == IDW'(gi))) begin
                        base_reg <= (cur_slot.block_count == 8'd0) ? 27'd0 : dst_reg;
                    end
                end
            end

            assign fw_ram_base[gi]  = base_reg;
            assign fw_ram_valid[gi] = valid_reg;
        end
    endgenerate

    assign update_ack    = (state_reg == S_ACK);
    assign ddr3_request  = (state_reg != S_IDLE) && (state_reg != S_ACK);
    assign ddr3_rd       = ddr3_rd_reg;
    assign ddr3_addr     = ddr3_addr_reg;
    assign ram_we        = ram_we_reg;
    assign ram_addr      = ram_addr_reg;
    assign ram_din       = ram_din_reg;
    assign copy_overflow = overflow_reg;

endmodule

// File: tb/tb_fw_rom_copy.sv
// Directed bench for fw_rom_copy: one default instance and one with a low RAM_LIMIT,
// both using 256-byte blocks so every pass stays short.

module tb_fw_rom_copy;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, update_request, ddr3_ready, ram_ready;
    MSX::fw_rom_t [7:0] fw_store;

    logic             update_ack_a, ddr3_request_a, ddr3_rd_a, ram_we_a, copy_overflow_a;
    logic [27:0]      ddr3_addr_a;
    logic [7:0]       ddr3_dout_a, ram_din_a, fw_ram_valid_a;
    logic [26:0]      ram_addr_a;
    logic [7:0][26:0] fw_ram_base_a;

    logic             update_ack_b, ddr3_request_b, ddr3_rd_b, ram_we_b, copy_overflow_b;
    logic [27:0]      ddr3_addr_b;
    logic [7:0]       ddr3_dout_b, ram_din_b, fw_ram_valid_b;
    logic [26:0]      ram_addr_b;
    logic [7:0][26:0] fw_ram_base_b;

    function automatic logic [7:0] ddr_byte(input logic [27:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    // DDR3 source address that should land at SDRAM address a (256-byte blocks, base 0)
    function automatic logic [27:0] src_of(input logic [26:0] a);
        logic [27:0] base;
        logic [27:0] n;
        base = 28'd0;
        for (int i = 0; i < 8; i++) begin
            n = {20'd0, fw_store[i].block_count} << 8;
            if (({1'b0, a} >= base) && ({1'b0, a} < base + n))
                return fw_store[i].store_address + ({1'b0, a} - base);
            base = base + n;
        end
        return 28'hFFFFFFF;
    endfunction

    assign ddr3_dout_a = ddr_byte(ddr3_addr_a);
    assign ddr3_dout_b = ddr_byte(ddr3_addr_b);

    fw_rom_copy #(.MAX_FW_ROM(8), .RAM_BASE(27'h0), .RAM_LIMIT(27'h400000), .BLOCK_LOG2(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .update_request(update_request), .update_ack(update_ack_a),
        .fw_store(fw_store), .ddr3_request(ddr3_request_a), .ddr3_addr(ddr3_addr_a), .ddr3_rd(ddr3_rd_a),
        .ddr3_ready(ddr3_ready), .ddr3_dout(ddr3_dout_a), .ram_addr(ram_addr_a), .ram_din(ram_din_a),
        .ram_we(ram_we_a), .ram_ready(ram_ready), .fw_ram_base(fw_ram_base_a),
        .fw_ram_valid(fw_ram_valid_a), .copy_overflow(copy_overflow_a)
    );

    fw_rom_copy #(.MAX_FW_ROM(8), .RAM_BASE(27'h0), .RAM_LIMIT(27'h180), .BLOCK_LOG2(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .update_request(update_request), .update_ack(update_ack_b),
        .fw_store(fw_store), .ddr3_request(ddr3_request_b), .ddr3_addr(ddr3_addr_b), .ddr3_rd(ddr3_rd_b),
        .ddr3_ready(ddr3_ready), .ddr3_dout(ddr3_dout_b), .ram_addr(ram_addr_b), .ram_din(ram_din_b),
        .ram_we(ram_we_b), .ram_ready(ram_ready), .fw_ram_base(fw_ram_base_b),
        .fw_ram_valid(fw_ram_valid_b), .copy_overflow(copy_overflow_b)
    );

    // Ready generation: always-ready, or random 0..7 cycle stalls
    logic stall = 1'b0;
    int   dcnt = 0, rcnt = 0;
    initial begin
        ddr3_ready = 1'b1;
        ram_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!stall) begin
                ddr3_ready = 1'b1;
                ram_ready  = 1'b1;
            end else begin
                if (dcnt == 0) begin ddr3_ready = 1'b1; dcnt = $urandom_range(0, 7); end
                else begin ddr3_ready = 1'b0; dcnt--; end
                if (rcnt == 0) begin ram_ready = 1'b1; rcnt = $urandom_range(0, 7); end
                else begin ram_ready = 1'b0; rcnt--; end
            end
        end
    end

    int          wr_a, err_a, prot_a, ack_a, wr_b, err_b, prot_b, ack_b;
    logic [26:0] first_a, last_a, pra_a, last_b, pra_b;
    logic [27:0] pda_a, pda_b;
    logic        prd_a = 1'b0, pwe_a = 1'b0, prd_b = 1'b0, pwe_b = 1'b0;

    always @(negedge clk) begin
        if (ram_we_a && ram_ready) begin
            if (wr_a == 0) first_a = ram_addr_a;
            last_a = ram_addr_a;
            wr_a++;
            if (ram_din_a !== ddr_byte(src_of(ram_addr_a))) err_a++;
        end
        if (ddr3_rd_a && ram_we_a) prot_a++;
        if (ddr3_rd_a && prd_a && (ddr3_addr_a !== pda_a)) prot_a++;
        if (ram_we_a && pwe_a && (ram_addr_a !== pra_a)) prot_a++;
        prd_a = ddr3_rd_a; pda_a = ddr3_addr_a; pwe_a = ram_we_a; pra_a = ram_addr_a;
        if (update_ack_a) ack_a++;

        if (ram_we_b && ram_ready) begin
            last_b = ram_addr_b;
            wr_b++;
            if (ram_din_b !== ddr_byte(src_of(ram_addr_b))) err_b++;
        end
        if (ddr3_rd_b && ram_we_b) prot_b++;
        if (ddr3_rd_b && prd_b && (ddr3_addr_b !== pda_b)) prot_b++;
        if (ram_we_b && pwe_b && (ram_addr_b !== pra_b)) prot_b++;
        prd_b = ddr3_rd_b; pda_b = ddr3_addr_b; pwe_b = ram_we_b; pra_b = ram_addr_b;
        if (update_ack_b) ack_b++;
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clr();
        wr_a = 0; err_a = 0; prot_a = 0; ack_a = 0; first_a = '1; last_a = '1;
        wr_b = 0; err_b = 0; prot_b = 0; ack_b = 0; last_b = '1;
    endtask

    task automatic wait_acks(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while ((ack_a < n) && (c < budget)) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 64'(ack_a >= n), 64'd1);
    endtask

    task automatic set_single();
        fw_store = '0;
        fw_store[0].block_count   = 8'd1;
        fw_store[0].store_address = 28'h500010;
    endtask

    logic [26:0] exp_base [8];

    initial begin
        reset_n = 1'b0;
        update_request = 1'b0;
        fw_store = '0;
        clr();
        step(3);
        $display("reset state");
        chk("rst_ddr3_request", 64'(ddr3_request_a), 64'd0);
        chk("rst_ddr3_rd", 64'(ddr3_rd_a), 64'd0);
        chk("rst_ram_we", 64'(ram_we_a), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr_a), 64'd0);
        chk("rst_valid", 64'(fw_ram_valid_a), 64'd0);
        chk("rst_ack", 64'(update_ack_a), 64'd0);
        chk("rst_overflow", 64'(copy_overflow_a), 64'd0);
        reset_n = 1'b1;
        step(2);

        // 1: single slot, always ready
        set_single();
        clr();
        update_request = 1'b1;
        wait_acks(1, 3000, "t1_ack_timeout");
        step(20);
        $display("t1 single slot: writes=%0d last=0x%0h acks=%0d", wr_a, last_a, ack_a);
        chk("t1_writes", 64'(wr_a), 64'd256);
        chk("t1_first", 64'(first_a), 64'h0);
        chk("t1_last", 64'(last_a), 64'hFF);
        chk("t1_data_errs", 64'(err_a), 64'd0);
        chk("t1_base0", 64'(fw_ram_base_a[0]), 64'h0);
        chk("t1_valid", 64'(fw_ram_valid_a), 64'h01);
        chk("t1_overflow", 64'(copy_overflow_a), 64'd0);
        chk("t1_acks", 64'(ack_a), 64'd1);
        chk("t1_protocol", 64'(prot_a), 64'd0);
        update_request = 1'b0;
        step(3);

        // 2: slots 0,1(x2),3 with empty slots in between
        fw_store = '0;
        fw_store[0].block_count = 8'd1; fw_store[0].store_address = 28'h0100000;
        fw_store[1].block_count = 8'd2; fw_store[1].store_address = 28'h0200000;
        fw_store[3].block_count = 8'd1; fw_store[3].store_address = 28'h0300000;
        exp_base = '{27'h0, 27'h100, 27'h0, 27'h300, 27'h0, 27'h0, 27'h0, 27'h0};
        clr();
        update_request = 1'b1;
        wait_acks(1, 8000, "t2_ack_timeout");
        step(20);
        $display("t2 multi slot: writes=%0d last=0x%0h valid=0x%0h", wr_a, last_a, fw_ram_valid_a);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2_base%0d", i), 64'(fw_ram_base_a[i]), 64'(exp_base[i]));
        chk("t2_valid", 64'(fw_ram_valid_a), 64'h0B);
        chk("t2_writes", 64'(wr_a), 64'd1024);
        chk("t2_last", 64'(last_a), 64'h3FF);
        chk("t2_data_errs", 64'(err_a), 64'd0);
        chk("t2_acks", 64'(ack_a), 64'd1);
        update_request = 1'b0;
        step(3);

        // 3: random ready stalls
        set_single();
        stall = 1'b1;
        clr();
        update_request = 1'b1;
        wait_acks(1, 12000, "t3_ack_timeout");
        step(20);
        stall = 1'b0;
        $display("t3 stalls: writes=%0d last=0x%0h protocol_errs=%0d", wr_a, last_a, prot_a);
        chk("t3_writes", 64'(wr_a), 64'd256);
        chk("t3_last", 64'(last_a), 64'hFF);
        chk("t3_data_errs", 64'(err_a), 64'd0);
        chk("t3_protocol", 64'(prot_a), 64'd0);
        chk("t3_valid", 64'(fw_ram_valid_a), 64'h01);
        chk("t3_acks", 64'(ack_a), 64'd1);
        update_request = 1'b0;
        step(3);

        // 4: RAM_LIMIT truncation on the limited instance
        fw_store = '0;
        fw_store[0].block_count = 8'd1; fw_store[0].store_address = 28'h500010;
        fw_store[1].block_count = 8'd1; fw_store[1].store_address = 28'h600000;
        clr();
        update_request = 1'b1;
        wait_acks(1, 4000, "t4_ack_timeout");
        step(20);
        $display("t4 limit: writes=%0d last=0x%0h valid=0x%0h ovf=%0d", wr_b, last_b, fw_ram_valid_b, copy_overflow_b);
        chk("t4_writes", 64'(wr_b), 64'h180);
        chk("t4_last", 64'(last_b), 64'h17F);
        chk("t4_data_errs", 64'(err_b), 64'd0);
        chk("t4_valid", 64'(fw_ram_valid_b), 64'h01);
        chk("t4_base1", 64'(fw_ram_base_b[1]), 64'h100);
        chk("t4_overflow", 64'(copy_overflow_b), 64'd1);
        chk("t4_acks", 64'(ack_b), 64'd1);
        chk("t4_protocol", 64'(prot_b), 64'd0);
        chk("t4_unlimited_valid", 64'(fw_ram_valid_a), 64'h03);
        chk("t4_unlimited_overflow", 64'(copy_overflow_a), 64'd0);
        update_request = 1'b0;
        step(3);

        // 5: asynchronous reset mid-slot
        set_single();
        clr();
        update_request = 1'b1;
        step(100);
        chk("t5_mid_slot", 64'((wr_a > 0) && (wr_a < 256)), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        $display("t5 async reset: request=%0d rd=%0d we=%0d", ddr3_request_a, ddr3_rd_a, ram_we_a);
        chk("t5_ddr3_request", 64'(ddr3_request_a), 64'd0);
        chk("t5_ddr3_rd", 64'(ddr3_rd_a), 64'd0);
        chk("t5_ddr3_addr", 64'(ddr3_addr_a), 64'd0);
        chk("t5_ram_we", 64'(ram_we_a), 64'd0);
        chk("t5_ram_addr", 64'(ram_addr_a), 64'd0);
        chk("t5_ram_din", 64'(ram_din_a), 64'd0);
        update_request = 1'b0;
        step(5);
        chk("t5_no_ack", 64'(ack_a), 64'd0);
        reset_n = 1'b1;
        step(3);
        clr();
        update_request = 1'b1;
        wait_acks(1, 3000, "t5_ack_timeout");
        step(20);
        chk("t5_first", 64'(first_a), 64'h0);
        chk("t5_writes", 64'(wr_a), 64'd256);
        chk("t5_last", 64'(last_a), 64'hFF);
        chk("t5_data_errs", 64'(err_a), 64'd0);
        chk("t5_valid", 64'(fw_ram_valid_a), 64'h01);
        chk("t5_acks", 64'(ack_a), 64'd1);
        update_request = 1'b0;
        step(3);

        // 6: second request edge while a pass is running
        clr();
        update_request = 1'b1;
        step(100);
        update_request = 1'b0;
        step(3);
        update_request = 1'b1;
        wait_acks(2, 6000, "t6_ack_timeout");
        step(200);
        $display("t6 queued request: acks=%0d writes=%0d", ack_a, wr_a);
        chk("t6_acks", 64'(ack_a), 64'd2);
        chk("t6_writes", 64'(wr_a), 64'd512);
        chk("t6_first", 64'(first_a), 64'h0);
        chk("t6_last", 64'(last_a), 64'hFF);
        chk("t6_data_errs", 64'(err_a), 64'd0);
        chk("t6_valid", 64'(fw_ram_valid_a), 64'h01);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
